// File: rtl/mcu0_pkg.sv
// mcu0_pkg
//   Shared definitions for the MCU0 control sequencer: opcode values decoded
//   from ir[15:12], ALU operation codes driven on alu_op, FSM state encoding,
//   error codes reported on err, and default timeout parameters.
package mcu0_pkg;

  // Default timeout settings.
  // The wait counter must be wide enough to hold WAIT_MAX.
  localparam int WAIT_MAX_DEFAULT = 15;
  localparam int TW_DEFAULT       = 4;

  // Opcodes (ir[15:12]). Values 6..F are illegal.
  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_JEQ = 4'h5;

  // ALU operation codes.
  // NOP passes the memory operand through to the ALU output.
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;

  // Error codes.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // FSM state encoding.
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // True for opcodes that need a second memory access through the MEM state.
  function automatic logic needs_mem(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_ST) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/mcu0_wait_timer.sv
// mcu0_wait_timer
//   Counts cycles in which a memory request is outstanding but unanswered.
//   It flags a timeout in the cycle the count would reach WAIT_MAX.
// Ports
//   clock    in  system clock, rising edge
//   reset    in  asynchronous active-high reset; clears the count
//   clear    in  restart the count (no request waiting this cycle)
//   count    in  a request is waiting this cycle (mem_req=1, mem_ready=0)
//   expired  out this waiting cycle is number WAIT_MAX; the access has timed out
module mcu0_wait_timer
  import mcu0_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter int TW       = TW_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [TW-1:0] cnt;

  // The count saturates at WAIT_MAX.
  // In practice the sequencer leaves the waiting state as soon as
  // expired rises, so the count never needs to go past that value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != TW'(WAIT_MAX))) begin
      cnt <= cnt + TW'(1);
    end
  end

  // expired is based on the increment happening in this cycle.
  // A mem_ready in the same cycle drops count, so the completed access wins.
  assign expired = count && (cnt == TW'(WAIT_MAX - 1));

endmodule

// File: rtl/mcu0_sequencer.sv
// mcu0_sequencer
//   Multi-cycle control FSM for the MCU0 accumulator datapath. It sequences
//   fetch/decode/execute for LD, ADD, JMP, ST, CMP and JEQ. It drives the
//   register load strobes, the PC and address mux selects, the ALU op and the
//   memory request. It also holds the N/Z status flags.
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   run               1 = a new instruction fetch may start
//   ir                current IR; ir[15:12] opcode, ir[11:0] operand C (used by datapath)
//   mem_ready         memory completes the current access this cycle
//   alu_zero/alu_neg  ALU result status, captured into the flags on CMP
//   pc_load, pc_sel   PC load strobe; select 0: PC+2, 1: {4'h0, C}
//   ir_load, a_load   IR / A load strobes
//   alu_op            ALU operation (0 when unused)
//   mem_req, mem_we   memory request and write enable (A -> mem[C])
//   addr_sel          address select 0: PC, 1: {4'h0, C}
//   sw_n, sw_z        negative / zero flags
//   halted, err       in HALT; error code (0 none, 1 illegal, 2 timeout)
//   state_dbg         current FSM state, for observation only
//
// Memory handshake
//   mem_req is raised by the sequencer and held until the first cycle in
//   which mem_ready=1. That cycle completes the access and its strobes
//   (ir_load, a_load, flag capture) take effect at the end of the cycle.
//   mem_ready is ignored whenever mem_req=0. A request left unanswered for
//   WAIT_MAX cycles is abandoned: the FSM halts with err=2 and mem_req drops.
module mcu0_sequencer
  import mcu0_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter int TW       = TW_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  input  logic [15:0]  ir,
  input  logic         mem_ready,
  input  logic         alu_zero,
  input  logic         alu_neg,
  output logic         pc_load,
  output logic         pc_sel,
  output logic         ir_load,
  output logic         a_load,
  output logic [3:0]   alu_op,
  output logic         mem_req,
  output logic         mem_we,
  output logic         addr_sel,
  output logic         sw_n,
  output logic         sw_z,
  output logic         halted,
  output logic [1:0]   err,
  output state_t       state_dbg
);

  state_t      state, state_next;
  logic        pending, pending_next;
  logic        flag_load;
  logic        err_set;
  logic [1:0]  err_next;
  logic [1:0]  err_q;
  logic        req_active;
  logic        wait_count;
  logic        expired;
  logic [3:0]  op;

  // The operand field only feeds the datapath muxes, not the sequencer.
  logic        unused_ir;

  assign op        = ir[15:12];
  assign unused_ir = ^ir[11:0];

  // The request condition is kept separate from the output decode.
  // This way the timer input does not depend on the same always_comb
  // block that consumes expired.
  assign req_active = ((state == ST_FETCH) && (run || pending)) || (state == ST_MEM);
  assign wait_count = req_active && !mem_ready;

  mcu0_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .TW       (TW)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!wait_count),
    .count   (wait_count),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // pending remembers that a fetch request went out.
  // Once raised, the request survives run dropping before mem_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      pending <= pending_next;
    end
  end

  // Status flags change only when a CMP access completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_n <= 1'b0;
      sw_z <= 1'b0;
    end else if (flag_load) begin
      sw_n <= alu_neg;
      sw_z <= alu_zero;
    end
  end

  // Error code; written only on the transition into HALT.
  // It is then held until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= ERR_NONE;
    end else if (err_set) begin
      err_q <= err_next;
    end
  end

  // Next state and strobe decode
  always_comb begin
    state_next   = state;
    pending_next = pending;
    flag_load    = 1'b0;
    err_set      = 1'b0;
    err_next     = ERR_NONE;
    pc_load      = 1'b0;
    pc_sel       = 1'b0;
    ir_load      = 1'b0;
    a_load       = 1'b0;
    alu_op       = ALU_NOP;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;

    case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (run || pending) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load      = 1'b1;
            pc_load      = 1'b1;
            pending_next = 1'b0;
            state_next   = ST_DECODE;
          end else if (expired) begin
            pending_next = 1'b0;
            err_set      = 1'b1;
            err_next     = ERR_TIMEOUT;
            state_next   = ST_HALT;
          end else begin
            pending_next = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        if (op == OP_JMP) begin
          pc_load    = 1'b1;
          pc_sel     = 1'b1;
          state_next = ST_FETCH;
        end else if (op == OP_JEQ) begin
          pc_load    = sw_z;
          pc_sel     = sw_z;
          state_next = ST_FETCH;
        end else if (needs_mem(op)) begin
          state_next = ST_MEM;
        end else begin
          err_set    = 1'b1;
          err_next   = ERR_ILLEGAL;
          state_next = ST_HALT;
        end
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op == OP_ST);
        if (mem_ready) begin
          state_next = ST_FETCH;
          case (op)
            OP_LD: begin
              a_load = 1'b1;
              alu_op = ALU_NOP;
            end
            OP_ADD: begin
              a_load = 1'b1;
              alu_op = ALU_ADD;
            end
            OP_CMP: begin
              alu_op    = ALU_SUB;
              flag_load = 1'b1;
            end
            default: begin
              // ST: the write completes, nothing is loaded.
            end
          endcase
        end else if (expired) begin
          err_set    = 1'b1;
          err_next   = ERR_TIMEOUT;
          state_next = ST_HALT;
        end
      end

      ST_HALT: begin
        // Terminal: only reset leaves.
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  assign halted    = (state == ST_HALT);
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mcu0_sequencer.sv
// tb_mcu0_sequencer
//   Directed bench for mcu0_sequencer. Each stimulus cycle pushes the
//   hand-computed output vector for that cycle into exp_q. A monitor
//   samples the DUT on the falling edge, pops and compares.
module tb_mcu0_sequencer;

  localparam int W = 16;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        run = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;
  logic        pc_load, pc_sel, ir_load, a_load;
  logic [3:0]  alu_op;
  logic        mem_req, mem_we, addr_sel, sw_n, sw_z, halted;
  logic [1:0]  err;
  logic [2:0]  state_dbg;

  mcu0_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .ir        (ir),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .alu_neg   (alu_neg),
    .pc_load   (pc_load),
    .pc_sel    (pc_sel),
    .ir_load   (ir_load),
    .a_load    (a_load),
    .alu_op    (alu_op),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .sw_n      (sw_n),
    .sw_z      (sw_z),
    .halted    (halted),
    .err       (err),
    .state_dbg (state_dbg)
  );

  logic [W-1:0] act;
  assign act = {pc_load, pc_sel, ir_load, a_load, alu_op,
                mem_req, mem_we, addr_sel, sw_n, sw_z, halted, err};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // Expected-vector builders
  function automatic logic [W-1:0] v(input logic pcl, input logic pcs, input logic irl,
                                     input logic al, input logic [3:0] alu, input logic req,
                                     input logic we, input logic asel, input logic n,
                                     input logic z, input logic h, input logic [1:0] e);
    return {pcl, pcs, irl, al, alu, req, we, asel, n, z, h, e};
  endfunction

  function automatic logic [W-1:0] e_zero(input logic n, input logic z);
    return v(0, 0, 0, 0, 4'd0, 0, 0, 0, n, z, 0, 2'd0);
  endfunction

  function automatic logic [W-1:0] e_fetch_wait(input logic n, input logic z);
    return v(0, 0, 0, 0, 4'd0, 1, 0, 0, n, z, 0, 2'd0);
  endfunction

  function automatic logic [W-1:0] e_fetch_done(input logic n, input logic z);
    return v(1, 0, 1, 0, 4'd0, 1, 0, 0, n, z, 0, 2'd0);
  endfunction

  function automatic logic [W-1:0] e_mem(input logic we, input logic n, input logic z);
    return v(0, 0, 0, 0, 4'd0, 1, we, 1, n, z, 0, 2'd0);
  endfunction

  function automatic logic [W-1:0] e_mem_done(input logic al, input logic [3:0] alu,
                                              input logic we, input logic n, input logic z);
    return v(0, 0, 0, al, alu, 1, we, 1, n, z, 0, 2'd0);
  endfunction

  function automatic logic [W-1:0] e_jump(input logic n, input logic z);
    return v(1, 1, 0, 0, 4'd0, 0, 0, 0, n, z, 0, 2'd0);
  endfunction

  function automatic logic [W-1:0] e_halt(input logic n, input logic z, input logic [1:0] e);
    return v(0, 0, 0, 0, 4'd0, 0, 0, 0, n, z, 1, e);
  endfunction

  // Driver: one clock cycle of inputs plus its expected outputs.
  task automatic cyc(input logic rst, input logic r, input logic [15:0] i, input logic rd,
                     input logic az, input logic an, input logic [W-1:0] e, input string nm);
    @(posedge clock);
    #1;
    reset     = rst;
    run       = r;
    ir        = i;
    mem_ready = rd;
    alu_zero  = az;
    alu_neg   = an;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  initial begin
    // Reset held: every output 0 even with run and mem_ready active.
    cyc(1, 1, 16'h0010, 1, 0, 0, e_zero(0, 0), "rst_hold");
    cyc(1, 1, 16'h0010, 1, 0, 0, e_zero(0, 0), "rst_hold");
    cyc(0, 0, 16'h0010, 0, 0, 0, e_zero(0, 0), "boot");

    // run=0: FETCH idles. mem_ready without a request is ignored.
    cyc(0, 0, 16'h0010, 0, 0, 0, e_zero(0, 0), "fetch_idle");
    cyc(0, 0, 16'h0010, 0, 0, 0, e_zero(0, 0), "fetch_idle");
    cyc(0, 0, 16'h0010, 1, 0, 0, e_zero(0, 0), "ready_ignored");

    // LD with late memory. The request persists after run drops.
    cyc(0, 1, 16'h0010, 0, 0, 0, e_fetch_wait(0, 0), "fetch_run");
    cyc(0, 0, 16'h0010, 0, 0, 0, e_fetch_wait(0, 0), "fetch_hold");
    cyc(0, 0, 16'h0010, 1, 0, 0, e_fetch_done(0, 0), "fetch_done");
    cyc(0, 0, 16'h0010, 0, 0, 0, e_zero(0, 0), "ld_decode");
    cyc(0, 0, 16'h0010, 0, 0, 0, e_mem(0, 0, 0), "ld_mem_wait");
    cyc(0, 0, 16'h0010, 0, 0, 0, e_mem(0, 0, 0), "ld_mem_wait");
    cyc(0, 0, 16'h0010, 1, 0, 0, e_mem_done(1, 4'd0, 0, 0, 0), "ld_mem_done");

    // CMP with zero result sets Z; JEQ is then taken.
    cyc(0, 1, 16'h4000, 1, 0, 0, e_fetch_done(0, 0), "cmp_fetch");
    cyc(0, 1, 16'h4000, 0, 0, 0, e_zero(0, 0), "cmp_decode");
    cyc(0, 1, 16'h4000, 1, 1, 0, e_mem_done(0, 4'd2, 0, 0, 0), "cmp_mem");
    cyc(0, 1, 16'h5008, 1, 0, 0, e_fetch_done(0, 1), "jeq_fetch");
    cyc(0, 1, 16'h5008, 0, 0, 0, e_jump(0, 1), "jeq_taken");

    // CMP with negative, nonzero result; JEQ is then not taken.
    cyc(0, 1, 16'h4000, 1, 0, 0, e_fetch_done(0, 1), "cmp2_fetch");
    cyc(0, 1, 16'h4000, 0, 0, 0, e_zero(0, 1), "cmp2_decode");
    cyc(0, 1, 16'h4000, 1, 0, 1, e_mem_done(0, 4'd2, 0, 0, 1), "cmp2_mem");
    cyc(0, 1, 16'h5008, 1, 0, 0, e_fetch_done(1, 0), "jeq2_fetch");
    cyc(0, 1, 16'h5008, 0, 0, 0, e_zero(1, 0), "jeq_not_taken");

    // JMP
    cyc(0, 1, 16'h2123, 1, 0, 0, e_fetch_done(1, 0), "jmp_fetch");
    cyc(0, 1, 16'h2123, 0, 0, 0, e_jump(1, 0), "jmp_decode");

    // ST: write enable throughout MEM, no A load. ALU status does not touch flags.
    cyc(0, 1, 16'h3020, 1, 0, 0, e_fetch_done(1, 0), "st_fetch");
    cyc(0, 1, 16'h3020, 0, 1, 0, e_zero(1, 0), "st_decode");
    cyc(0, 1, 16'h3020, 0, 1, 0, e_mem(1, 1, 0), "st_mem_wait");
    cyc(0, 1, 16'h3020, 1, 1, 0, e_mem_done(0, 4'd0, 1, 1, 0), "st_mem_done");

    // ADD
    cyc(0, 1, 16'h1005, 1, 0, 0, e_fetch_done(1, 0), "add_fetch");
    cyc(0, 1, 16'h1005, 0, 0, 0, e_zero(1, 0), "add_decode");
    cyc(0, 1, 16'h1005, 1, 0, 0, e_mem_done(1, 4'd1, 0, 1, 0), "add_mem_done");

    // mem_ready on the 15th waiting cycle beats the timeout.
    for (int k = 0; k < 14; k++) begin
      cyc(0, 1, 16'h0010, 0, 0, 0, e_fetch_wait(1, 0), "late_wait");
    end
    cyc(0, 1, 16'h0010, 1, 0, 0, e_fetch_done(1, 0), "late_ready_wins");
    cyc(0, 1, 16'h0010, 0, 0, 0, e_zero(1, 0), "late_decode");
    cyc(0, 1, 16'h0010, 1, 0, 0, e_mem_done(1, 4'd0, 0, 1, 0), "late_ld_done");

    // Illegal opcode halts with err=1 and stays halted.
    cyc(0, 1, 16'hF000, 1, 0, 0, e_fetch_done(1, 0), "ill_fetch");
    cyc(0, 1, 16'hF000, 0, 0, 0, e_zero(1, 0), "ill_decode");
    cyc(0, 1, 16'hF000, 1, 0, 0, e_halt(1, 0, 2'd1), "ill_halt");
    cyc(0, 1, 16'hF000, 1, 0, 0, e_halt(1, 0, 2'd1), "ill_halt");

    // Reset leaves HALT. Then reset again mid-way through a ST access.
    cyc(1, 1, 16'h3020, 0, 0, 0, e_zero(0, 0), "rst_in_halt");
    cyc(0, 1, 16'h3020, 0, 0, 0, e_zero(0, 0), "boot2");
    cyc(0, 1, 16'h3020, 1, 0, 0, e_fetch_done(0, 0), "st2_fetch");
    cyc(0, 1, 16'h3020, 0, 0, 0, e_zero(0, 0), "st2_decode");
    cyc(0, 1, 16'h3020, 0, 0, 0, e_mem(1, 0, 0), "st2_mem");
    cyc(1, 1, 16'h3020, 1, 0, 0, e_zero(0, 0), "rst_mid_mem");
    cyc(0, 1, 16'h3020, 0, 0, 0, e_zero(0, 0), "boot3");

    // Timeout: 15 unanswered request cycles, then HALT with err=2.
    for (int k = 0; k < 15; k++) begin
      cyc(0, 1, 16'h0010, 0, 0, 0, e_fetch_wait(0, 0), "to_wait");
    end
    cyc(0, 1, 16'h0010, 1, 0, 0, e_halt(0, 0, 2'd2), "to_halt");
    cyc(0, 1, 16'h0010, 1, 0, 0, e_halt(0, 0, 2'd2), "to_halt");

    // Let the monitor drain the queue, then report.
    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
